// File: rtl/uart_echo_responder.sv
// Far-end UART echo peer: receives 8N1 frames, buffers them in a small FIFO
// and re-transmits each byte on its own serial output.
module uart_echo_responder #(
  parameter int FREQUENCY  = 87,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_Serial_Data,
  input  logic                          i_Tx_Hold,
  output logic                          o_Serial_Data,
  output logic                          o_Rx_DV,
  output logic [7:0]                    o_Rx_Byte,
  output logic                          o_Frame_Err,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done
);

  localparam int CW = $clog2(FREQUENCY) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] BIT_LAST   = CW'(FREQUENCY - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(FREQUENCY / 2 - 1);
  localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_t;

  logic          rxMeta_q, rxSync_q;
  state_t        rxState_q;
  logic [CW-1:0] rxCnt_q;
  logic [2:0]    rxBitIdx_q;
  logic [7:0]    rxShift_q, rxByte_q;
  logic          rxDv_q, frameErr_q, overflow_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [NW-1:0] count_q, count_d;

  state_t        txState_q;
  logic [CW-1:0] txCnt_q;
  logic [2:0]    txBitIdx_q;
  logic [7:0]    txShift_q;
  logic          txLine_q, txActive_q, txDone_q;

  logic pushReq, popReq, pushOk;

  assign pushReq = (rxState_q == S_STOP) && (rxCnt_q == BIT_LAST) && rxSync_q;
  assign popReq  = (txState_q == S_IDLE) && (count_q != '0) && !i_Tx_Hold;
  // A full FIFO still accepts a byte when the TX side drains one in the same cycle.
  assign pushOk  = pushReq && ((count_q != FULL_COUNT) || popReq);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
    if (popReq) rdPtr_d = rdPtr_q + 1'b1;
    case ({pushOk, popReq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= i_Serial_Data;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= rxShift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState_q  <= S_IDLE;
      rxCnt_q    <= '0;
      rxBitIdx_q <= '0;
      rxShift_q  <= '0;
      rxByte_q   <= '0;
      rxDv_q     <= 1'b0;
      frameErr_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rxDv_q     <= 1'b0;
      frameErr_q <= 1'b0;
      overflow_q <= 1'b0;
      case (rxState_q)
        S_IDLE: begin
          rxCnt_q    <= '0;
          rxBitIdx_q <= '0;
          if (!rxSync_q) rxState_q <= S_START;
        end
        S_START: begin
          if (rxCnt_q != HALF_LAST) begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end else begin
            rxCnt_q   <= '0;
            rxState_q <= rxSync_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rxCnt_q != BIT_LAST) begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end else begin
            rxCnt_q    <= '0;
            rxShift_q  <= {rxSync_q, rxShift_q[7:1]};
            rxBitIdx_q <= rxBitIdx_q + 1'b1;
            if (rxBitIdx_q == 3'd7) rxState_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (rxCnt_q != BIT_LAST) begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end else begin
            rxCnt_q   <= '0;
            rxState_q <= S_CLEANUP;
            if (!rxSync_q) begin
              frameErr_q <= 1'b1;
            end else if (pushOk) begin
              rxByte_q <= rxShift_q;
              rxDv_q   <= 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        S_CLEANUP: begin
          rxCnt_q   <= '0;
          rxState_q <= S_IDLE;
        end
        default: rxState_q <= S_IDLE;
      endcase
    end
  end

  // The serial line is a registered output so a reset forces it high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState_q  <= S_IDLE;
      txCnt_q    <= '0;
      txBitIdx_q <= '0;
      txShift_q  <= '0;
      txLine_q   <= 1'b1;
      txActive_q <= 1'b0;
      txDone_q   <= 1'b0;
    end else begin
      case (txState_q)
        S_IDLE: begin
          txCnt_q    <= '0;
          txBitIdx_q <= '0;
          txDone_q   <= 1'b0;
          txLine_q   <= 1'b1;
          txActive_q <= 1'b0;
          if (popReq) begin
            txShift_q  <= mem_q[rdPtr_q];
            txLine_q   <= 1'b0;
            txActive_q <= 1'b1;
            txState_q  <= S_START;
          end
        end
        S_START: begin
          if (txCnt_q != BIT_LAST) begin
            txCnt_q <= txCnt_q + 1'b1;
          end else begin
            txCnt_q   <= '0;
            txLine_q  <= txShift_q[0];
            txShift_q <= {1'b0, txShift_q[7:1]};
            txState_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (txCnt_q != BIT_LAST) begin
            txCnt_q <= txCnt_q + 1'b1;
          end else begin
            txCnt_q <= '0;
            if (txBitIdx_q == 3'd7) begin
              txLine_q  <= 1'b1;
              txState_q <= S_STOP;
            end else begin
              txBitIdx_q <= txBitIdx_q + 1'b1;
              txLine_q   <= txShift_q[0];
              txShift_q  <= {1'b0, txShift_q[7:1]};
            end
          end
        end
        S_STOP: begin
          if (txCnt_q != BIT_LAST) begin
            txCnt_q <= txCnt_q + 1'b1;
          end else begin
            txCnt_q    <= '0;
            txActive_q <= 1'b0;
            txDone_q   <= 1'b1;
            txState_q  <= S_CLEANUP;
          end
        end
        S_CLEANUP: begin
          txCnt_q   <= '0;
          txDone_q  <= 1'b0;
          txState_q <= S_IDLE;
        end
        default: txState_q <= S_IDLE;
      endcase
    end
  end

  assign o_Serial_Data = txLine_q;
  assign o_Rx_DV       = rxDv_q;
  assign o_Rx_Byte     = rxByte_q;
  assign o_Frame_Err   = frameErr_q;
  assign o_Overflow    = overflow_q;
  assign o_Fifo_Count  = count_q;
  assign o_Tx_Active   = txActive_q;
  assign o_Tx_Done     = txDone_q;

endmodule

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
Far-end UART peer for the loopback link: deserialises 8N1 frames from the serial line, buffers received bytes in a small FIFO, and re-serialises them back onto its own serial output. It is the remote responder the link tests talk to. It carries its own RX and TX datapaths and shares the link's bit-timing parameter. It exposes status pulses for receive, framing error and overflow.

Parameters:
FREQUENCY, 87, clock cycles per bit (minimum 4)
FIFO_DEPTH, 4, byte entries in the echo buffer (power of 2, ≥2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_Serial_Data  input  1  incoming UART line, idle high
i_Tx_Hold  input  1  flow control; high blocks starting a new TX frame, and an in-flight frame completes
o_Serial_Data  output  1  outgoing UART line, idle high
o_Rx_DV  output  1  one-cycle pulse, valid byte received
o_Rx_Byte  output  8  last valid received byte, held until the next valid byte
o_Frame_Err  output  1  one-cycle pulse, stop bit sampled low
o_Overflow  output  1  one-cycle pulse, valid byte dropped because FIFO full
o_Fifo_Count  output  clog2(FIFO_DEPTH)+1  entries currently buffered
o_Tx_Active  output  1  high from the first start-bit cycle to the last stop-bit cycle
o_Tx_Done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset (async assert, sync release): o_Serial_Data=1, all pulses=0, o_Rx_Byte=0, o_Fifo_Count=0, o_Tx_Active=0; both FSMs go to IDLE; FIFO is emptied; synchroniser flops preset to 1.
- Reset mid-frame: o_Serial_Data goes high immediately. No Done or DV pulse follows. The partial byte is lost.
- RX input passes through a 2-flop synchroniser; all RX timing below is relative to the synchronised signal.
- RX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: wait for synchronised line = 0.
  - START: count FREQUENCY/2 cycles, then resample. If low, clear the counter and go to DATA. If high, treat as a glitch and return to IDLE with no pulse.
  - DATA: sample every FREQUENCY cycles, 8 bits, LSB first, into a shift register.
  - STOP: sample after FREQUENCY cycles. If 1, update o_Rx_Byte, pulse o_Rx_DV and push to the FIFO. If 0, pulse o_Frame_Err and discard the byte (no push, o_Rx_Byte unchanged).
  - CLEANUP: 1 cycle, then IDLE.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Push when full (count==FIFO_DEPTH before this cycle's pop) drops the byte, pulses o_Overflow, and does not pulse o_Rx_DV.
  - Exception: a push and a pop in the same cycle while full is accepted; count stays FIFO_DEPTH and there is no overflow.
  - Push and pop in the same cycle at any other count leaves the count unchanged.
- TX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: pop when count>0 and i_Tx_Hold=0, latching the byte. START begins the next cycle.
  - START: line 0 for FREQUENCY cycles.
  - DATA: 8 bits LSB first, FREQUENCY cycles each.
  - STOP: line 1 for FREQUENCY cycles.
  - CLEANUP: 1 cycle with o_Tx_Done=1 and o_Tx_Active=0, then IDLE.
  - Back-to-back frames therefore have a minimum gap of 2 idle-high cycles (CLEANUP + IDLE pop).
  - i_Tx_Hold is sampled only in IDLE.
- Echo latency: FIFO push at the RX stop sample; the TX start bit begins 2 cycles later if TX is idle and not held.
- Counters are sized clog2(FREQUENCY)+1 bits and reset to 0 on every state transition.

Test Plan:
1. FREQUENCY=87, send 0xA5 frame on i_Serial_Data -> o_Rx_DV pulse with o_Rx_Byte=0xA5. o_Serial_Data then emits bits 0,1,0,1,0,0,1,0,1,1, each 87 cycles. One o_Tx_Done pulse follows, and o_Fifo_Count returns to 0.
2. Line low for 20 cycles, then high -> no o_Rx_DV, no o_Frame_Err, o_Serial_Data stays 1, RX back in IDLE.
3. Send 0x3C with stop bit 0 -> o_Frame_Err pulse, no o_Rx_DV, o_Rx_Byte unchanged, no echo, o_Fifo_Count=0.
4. i_Tx_Hold=1, send 0x01..0x05 -> count reaches 4 and the 5th byte gives an o_Overflow pulse. Release hold -> echoes 0x01, 0x02, 0x03, 0x04 in order, gaps of 2 cycles, then count=0.
5. Hold with FIFO full. Release hold so that the IDLE pop coincides with the stop sample of a 5th byte 0x77 -> no overflow, count stays 4. 0x77 is echoed last.
6. Pull rst_n low during TX data bit 3 -> o_Serial_Data=1 asynchronously, count=0, no o_Tx_Done. After release, a new 0x5A frame echoes correctly.
